lab2_proc_mem_responder: RTL and testbench
==========================================

// Module: lab2_proc_mem_responder
//
// PURPOSE
// Memory-side responder for the processor's val/rdy memory ports: accepts
// mem_req_4B_t requests, performs read/write/init on an internal word array,
// and returns mem_resp_4B_t responses in order after a fixed minimum latency.
// One instance serves one port, either imem or dmem, in processor test
// harnesses. It applies backpressure through reqstream_rdy and tolerates
// arbitrary respstream_rdy stalls.
//
// PARAMETERS
// p_mem_words  1024  number of 32-bit words (power of 2, >=2)
// p_latency    1     cycles from request accept edge to earliest resp_val (1..8)
//
// PORTS
// clk                  in   1   clock, rising edge
// reset                in   1   asynchronous, active-low reset (asserted when 0)
// reqstream_msg        in   77  mem_req_4B_t {type_,opaque,addr,len,data}
// reqstream_val        in   1   request valid
// reqstream_rdy        out  1   request ready
// respstream_msg       out  47  mem_resp_4B_t {type_,opaque,test,len,data}
// respstream_val       out  1   response valid
// respstream_rdy       in   1   response ready
//
// BEHAVIOUR
// - Reset (reset==0, async): occupancy=0, all delay-stage valids=0,
//   FIFO pointers=0, respstream_val=0, reqstream_rdy=0 while asserted.
//   Array contents are not reset. In-flight requests are dropped.
// - Fire rules: req fires when reqstream_val&&reqstream_rdy; resp fires
//   when respstream_val&&respstream_rdy. respstream_msg holds stable while
//   val&&!rdy.
// - Capacity: N=p_latency+1 slots. occ counts accepted-not-yet-delivered
//   responses. reqstream_rdy = (occ<N), a function of registered state only.
//   occ: +1 on req fire, -1 on resp fire, unchanged when both fire.
//   Sustains 1 req/cycle when respstream_rdy=1.
// - Word index = addr[2 +: log2(p_mem_words)]. Upper address bits are
//   ignored, so addresses wrap. Byte offset = addr[1:0]. Byte count
//   nb = (len==0)?4:len.
// - Types: READ=3'd0, WRITE=3'd1, INIT=3'd2.
// - Array access happens at the accept edge.
//   WRITE/INIT: bytes offset..offset+nb-1 of the word are written from
//   data[8*nb-1:0]. Bytes past byte 3 are discarded (no cross-word).
//   READ: the same byte lanes are returned shifted to bit 0 and
//   zero-extended. A read in the cycle after a write to the same word
//   sees the new data.
// - Response fields: type_ and opaque echo the request. len echoes the
//   request. test=2'b00.
//   READ: data=read bytes. WRITE/INIT: data=0.
//   Any other type: no array update, data=0, test=2'b11.
// - Pipeline: p_latency-1 delay stages (valid+payload), then an in-order
//   response FIFO of depth N. Delay stages never stall, which the occ<N
//   check guarantees. FIFO full/empty use wrap-around pointers with an
//   extra wrap bit.
// - respstream_val = FIFO not empty. Earliest response is at cycle
//   T+p_latency for a request accepted at edge T.
// - Simultaneous enqueue and dequeue on a full FIFO is legal, since occ
//   already excludes overflow. Responses are strictly in acceptance order.
//
// TESTING
// 1 Reset: hold reset=0 3 cycles, then release -> resp_val=0, occ=0,
//   req_rdy=1 on the first cycle after release.
// 2 INIT addr 0x100 data 0xDEADBEEF len0, then READ 0x100 len0,
//   opaque 0x5A -> resp type0 opaque0x5A data 0xDEADBEEF test0.
//   With p_latency=3, the read response appears exactly 3 cycles after
//   its accept.
// 3 WRITE 0x104 len1 data 0xAB at addr 0x106, then READ 0x104 len0
//   -> data 0x00AB0000 (byte lane 2 only). READ 0x107 len1 -> data 0x0.
// 4 Back-to-back: 8 READs with resp_rdy=1 -> req_rdy stays 1 and 8
//   responses arrive in order, 1/cycle.
// 5 Backpressure: resp_rdy=0 with p_latency=2 -> exactly 3 requests
//   accepted, then req_rdy=0. Raise resp_rdy -> responses drain in order
//   and req_rdy returns 1.
// 6 Type 3'd3 request -> resp test=2'b11 data=0, array unchanged.
//   Reset mid-stream with 2 in flight -> no responses after release.

Source files
------------

// File: rtl/lab2_proc_mem_responder.sv
// Memory-side responder for a val/rdy memory port: byte-lane read/write/init on
// a word array, a fixed-latency delay line, then an in-order response FIFO.
module lab2_proc_mem_responder #(
    parameter int p_mem_words = 1024,
    parameter int p_latency   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [76:0] reqstream_msg,
    input  logic        reqstream_val,
    output logic        reqstream_rdy,
    output logic [46:0] respstream_msg,
    output logic        respstream_val,
    input  logic        respstream_rdy
);
    localparam int N  = p_latency + 1;
    localparam int D  = p_latency - 1;
    localparam int IW = $clog2(p_mem_words);
    localparam int AW = $clog2(N);
    localparam int OW = $clog2(N + 1);
    localparam logic [OW-1:0] OCC_MAX = OW'(N);

    localparam logic [2:0] TYPE_READ  = 3'd0;
    localparam logic [2:0] TYPE_WRITE = 3'd1;
    localparam logic [2:0] TYPE_INIT  = 3'd2;

    function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] len);
        int         nb;
        logic [3:0] m;
        nb = (len == 2'd0) ? 4 : int'(len);
        m  = '0;
        for (int b = 0; b < 4; b++) begin
            if (b >= int'(off) && b < int'(off) + nb) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] byte_expand(input logic [3:0] m);
        logic [31:0] e;
        for (int b = 0; b < 4; b++) e[8*b +: 8] = {8{m[b]}};
        return e;
    endfunction

    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        logic [AW:0] r;
        if (p[AW-1:0] == AW'(N - 1)) r = {~p[AW], {AW{1'b0}}};
        else                         r = {p[AW], p[AW-1:0] + 1'b1};
        return r;
    endfunction

    logic [2:0]  req_type;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_data;
    assign {req_type, req_opaque, req_addr, req_len, req_data} = reqstream_msg;

    logic unused_addr;
    assign unused_addr = ^req_addr[31:IW+2];

    logic [OW-1:0] occ_q, occ_d;
    logic          req_fire, resp_fire;

    assign reqstream_rdy = reset && (occ_q < OCC_MAX);
    assign req_fire      = reqstream_val && reqstream_rdy;
    assign resp_fire     = respstream_val && respstream_rdy;

    logic [31:0]   mem_q [p_mem_words];
    logic [IW-1:0] word_idx;
    logic [31:0]   lane_bits, cur_word, wr_word, rd_data;
    logic          is_read, is_write, bad_type;
    logic [46:0]   resp_new;

    assign word_idx = req_addr[2 +: IW];
    assign cur_word = mem_q[word_idx];

    always_comb begin
        lane_bits = byte_expand(lane_mask(req_addr[1:0], req_len));
        is_read   = (req_type == TYPE_READ);
        is_write  = (req_type == TYPE_WRITE) || (req_type == TYPE_INIT);
        bad_type  = !is_read && !is_write;
        // Shifting left drops any bytes that would spill past lane 3.
        wr_word   = (cur_word & ~lane_bits) | ((req_data << {req_addr[1:0], 3'b000}) & lane_bits);
        rd_data   = (cur_word & lane_bits) >> {req_addr[1:0], 3'b000};
        resp_new  = {req_type, req_opaque, (bad_type ? 2'b11 : 2'b00), req_len,
                     (is_read ? rd_data : 32'h0)};
    end

    always_ff @(posedge clk) begin
        if (req_fire && is_write) mem_q[word_idx] <= wr_word;
    end

    always_comb begin
        occ_d = occ_q;
        if (req_fire && !resp_fire)      occ_d = occ_q + 1'b1;
        else if (!req_fire && resp_fire) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    logic        enq_vld;
    logic [46:0] enq_msg;

    generate
        if (D == 0) begin : g_nodly
            assign enq_vld = req_fire;
            assign enq_msg = resp_new;
        end else begin : g_dly
            logic [D-1:0] dly_vld_q;
            logic [46:0]  dly_msg_q [D];

            // Delay line never stalls: occupancy admits only what the FIFO can absorb.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dly_vld_q <= '0;
                end else begin
                    dly_vld_q[0] <= req_fire;
                    for (int i = 1; i < D; i++) dly_vld_q[i] <= dly_vld_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                dly_msg_q[0] <= resp_new;
                for (int i = 1; i < D; i++) dly_msg_q[i] <= dly_msg_q[i-1];
            end

            assign enq_vld = dly_vld_q[D-1];
            assign enq_msg = dly_msg_q[D-1];
        end
    endgenerate

    logic [46:0] fifo_q [N];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;

    assign respstream_val = (wptr_q != rptr_q);
    assign respstream_msg = fifo_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = enq_vld   ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = resp_fire ? ptr_inc(rptr_q) : rptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_vld) fifo_q[wptr_q[AW-1:0]] <= enq_msg;
    end

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// Directed bench for lab2_proc_mem_responder: vector table through a latency-2
// instance plus burst, backpressure, reset and latency-3 timing sequences.
module tb_lab2_proc_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [76:0] req_msg;
    logic        req_val, req_rdy;
    logic [46:0] resp_msg;
    logic        resp_val, resp_rdy;
    logic [76:0] l3_req_msg;
    logic        l3_req_val, l3_req_rdy;
    logic [46:0] l3_resp_msg;
    logic        l3_resp_val, l3_resp_rdy;

    int nvec = 0;
    int nerr = 0;
    logic [46:0] expq   [$];
    logic [76:0] bq_req [$];
    logic [46:0] bq_exp [$];

    typedef struct {
        logic [2:0]  ty;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic [1:0]  etest;
        logic [31:0] edata;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;

    lab2_proc_mem_responder #(.p_mem_words(1024), .p_latency(2)) u_dut (
        .clk(clk), .reset(reset),
        .reqstream_msg(req_msg), .reqstream_val(req_val), .reqstream_rdy(req_rdy),
        .respstream_msg(resp_msg), .respstream_val(resp_val), .respstream_rdy(resp_rdy)
    );

    lab2_proc_mem_responder #(.p_mem_words(1024), .p_latency(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .reqstream_msg(l3_req_msg), .reqstream_val(l3_req_val), .reqstream_rdy(l3_req_rdy),
        .respstream_msg(l3_resp_msg), .respstream_val(l3_resp_val), .respstream_rdy(l3_resp_rdy)
    );

    function automatic logic [76:0] mkreq(input logic [2:0] ty, input logic [7:0] op,
                                          input logic [31:0] addr, input logic [1:0] len,
                                          input logic [31:0] data);
        return {ty, op, addr, len, data};
    endfunction

    function automatic logic [46:0] mkresp(input logic [2:0] ty, input logic [7:0] op,
                                           input logic [1:0] test, input logic [1:0] len,
                                           input logic [31:0] data);
        return {ty, op, test, len, data};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got %h required %h", name, got, want);
        end
    endtask

    // Scoreboard: every response that will fire at the next edge is compared in order.
    always @(negedge clk) begin
        if (reset === 1'b1 && resp_val === 1'b1 && resp_rdy === 1'b1) begin
            nvec++;
            if (expq.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_resp got %h required none", resp_msg);
            end else begin
                logic [46:0] e;
                e = expq.pop_front();
                if (resp_msg !== e) begin
                    nerr++;
                    $display("FAIL resp_op%h got %h required %h", e[43:36], resp_msg, e);
                end
            end
        end
    end

    task automatic send_one(input logic [76:0] m, input logic [46:0] e, input string nm);
        bit ok;
        ok = 1'b0;
        req_msg = m;
        req_val = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_rdy) begin
                ok = 1'b1;
                expq.push_back(e);
                break;
            end
        end
        if (!ok) check({nm, "_req_timeout"}, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        req_val = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while (expq.size() != 0 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (expq.size() != 0) begin
            check({nm, "_drain_timeout"}, 64'(expq.size()), 64'd0);
            expq.delete();
        end
    endtask

    task automatic burst(input int ncyc, output int acc, output int low);
        acc = 0;
        low = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (bq_req.size() == 0) break;
            req_val = 1'b1;
            req_msg = bq_req[0];
            @(negedge clk);
            if (req_rdy) begin
                expq.push_back(bq_exp.pop_front());
                bq_req.delete(0);
                acc++;
            end else begin
                low++;
            end
            @(posedge clk);
            #1;
        end
        req_val = 1'b0;
    endtask

    task automatic l3_txn(input logic [76:0] m, input logic [46:0] e, input string nm);
        int n;
        l3_req_msg = m;
        l3_req_val = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (l3_req_rdy) break;
        end
        check({nm, "_rdy"}, 64'(l3_req_rdy), 64'd1);
        @(posedge clk);
        #1;
        l3_req_val = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (l3_resp_val) break;
        end
        check({nm, "_lat"}, 64'(n), 64'd3);
        check({nm, "_msg"}, 64'(l3_resp_msg), 64'(e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, low;
        logic [46:0] held;

        tbl[0]  = '{3'd2, 8'h01, 32'h100,  2'd0, 32'hDEADBEEF, 2'd0, 32'h0};
        tbl[1]  = '{3'd0, 8'h5A, 32'h100,  2'd0, 32'h0,        2'd0, 32'hDEADBEEF};
        tbl[2]  = '{3'd2, 8'h02, 32'h104,  2'd0, 32'h0,        2'd0, 32'h0};
        tbl[3]  = '{3'd1, 8'h03, 32'h106,  2'd1, 32'hAB,       2'd0, 32'h0};
        tbl[4]  = '{3'd0, 8'h04, 32'h104,  2'd0, 32'h0,        2'd0, 32'h00AB0000};
        tbl[5]  = '{3'd0, 8'h05, 32'h107,  2'd1, 32'h0,        2'd0, 32'h0};
        tbl[6]  = '{3'd0, 8'h06, 32'h106,  2'd2, 32'h0,        2'd0, 32'h000000AB};
        tbl[7]  = '{3'd2, 8'h07, 32'h200,  2'd0, 32'h11223344, 2'd0, 32'h0};
        tbl[8]  = '{3'd1, 8'h08, 32'h203,  2'd2, 32'h0000CCBB, 2'd0, 32'h0};
        tbl[9]  = '{3'd0, 8'h09, 32'h200,  2'd0, 32'h0,        2'd0, 32'hBB223344};
        tbl[10] = '{3'd0, 8'h0A, 32'h201,  2'd2, 32'h0,        2'd0, 32'h00002233};
        tbl[11] = '{3'd0, 8'h0B, 32'h1200, 2'd0, 32'h0,        2'd0, 32'hBB223344};
        tbl[12] = '{3'd3, 8'h0C, 32'h200,  2'd0, 32'hFFFFFFFF, 2'd3, 32'h0};
        tbl[13] = '{3'd0, 8'h0D, 32'h200,  2'd0, 32'h0,        2'd0, 32'hBB223344};
        tbl[14] = '{3'd0, 8'h0E, 32'h202,  2'd3, 32'h0,        2'd0, 32'h0000BB22};
        tbl[15] = '{3'd0, 8'hFF, 32'h100,  2'd1, 32'h0,        2'd0, 32'h000000EF};
        tbl[16] = '{3'd1, 8'h10, 32'h100,  2'd3, 32'h00112233, 2'd0, 32'h0};
        tbl[17] = '{3'd0, 8'h11, 32'h100,  2'd0, 32'h0,        2'd0, 32'hDE112233};

        reset       = 1'b0;
        req_msg     = '0;
        req_val     = 1'b0;
        resp_rdy    = 1'b1;
        l3_req_msg  = '0;
        l3_req_val  = 1'b0;
        l3_resp_rdy = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", 64'(req_rdy), 64'd0);
        check("rst_resp_val", 64'(resp_val), 64'd0);
        check("rst_l3_req_rdy", 64'(l3_req_rdy), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_req_rdy", 64'(req_rdy), 64'd1);
        check("post_rst_resp_val", 64'(resp_val), 64'd0);
        check("post_rst_l3_req_rdy", 64'(l3_req_rdy), 64'd1);

        l3_txn(mkreq(3'd2, 8'h01, 32'h100, 2'd0, 32'hDEADBEEF),
               mkresp(3'd2, 8'h01, 2'd0, 2'd0, 32'h0), "l3_init");
        l3_txn(mkreq(3'd0, 8'h5A, 32'h100, 2'd0, 32'h0),
               mkresp(3'd0, 8'h5A, 2'd0, 2'd0, 32'hDEADBEEF), "l3_read");

        for (int i = 0; i < 18; i++) begin
            send_one(mkreq(tbl[i].ty, tbl[i].op, tbl[i].addr, tbl[i].len, tbl[i].data),
                     mkresp(tbl[i].ty, tbl[i].op, tbl[i].etest, tbl[i].len, tbl[i].edata), "tbl");
            wait_drain("tbl");
        end

        // Back-to-back: init then reads, first read hits the word written one cycle earlier.
        bq_req.push_back(mkreq(3'd2, 8'h20, 32'h300,  2'd0, 32'h0000CAFE));
        bq_exp.push_back(mkresp(3'd2, 8'h20, 2'd0, 2'd0, 32'h0));
        bq_req.push_back(mkreq(3'd0, 8'h21, 32'h300,  2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h21, 2'd0, 2'd0, 32'h0000CAFE));
        bq_req.push_back(mkreq(3'd0, 8'h22, 32'h100,  2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h22, 2'd0, 2'd0, 32'hDE112233));
        bq_req.push_back(mkreq(3'd0, 8'h23, 32'h104,  2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h23, 2'd0, 2'd0, 32'h00AB0000));
        bq_req.push_back(mkreq(3'd0, 8'h24, 32'h200,  2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h24, 2'd0, 2'd0, 32'hBB223344));
        bq_req.push_back(mkreq(3'd0, 8'h25, 32'h301,  2'd1, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h25, 2'd0, 2'd1, 32'h000000CA));
        bq_req.push_back(mkreq(3'd0, 8'h26, 32'h200,  2'd1, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h26, 2'd0, 2'd1, 32'h00000044));
        bq_req.push_back(mkreq(3'd0, 8'h27, 32'h1300, 2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h27, 2'd0, 2'd0, 32'h0000CAFE));
        bq_req.push_back(mkreq(3'd0, 8'h28, 32'h106,  2'd2, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h28, 2'd0, 2'd2, 32'h000000AB));
        burst(9, acc, low);
        check("b2b_accepted", 64'(acc), 64'd9);
        check("b2b_rdy_low_cycles", 64'(low), 64'd0);
        check("b2b_pending_after_last", 64'(expq.size()), 64'd2);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("b2b_pending_two_later", 64'(expq.size()), 64'd0);
        wait_drain("b2b");

        // Backpressure: three slots for latency 2, then stall until responses drain.
        resp_rdy = 1'b0;
        bq_req.push_back(mkreq(3'd0, 8'h30, 32'h100, 2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h30, 2'd0, 2'd0, 32'hDE112233));
        bq_req.push_back(mkreq(3'd0, 8'h31, 32'h104, 2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h31, 2'd0, 2'd0, 32'h00AB0000));
        bq_req.push_back(mkreq(3'd0, 8'h32, 32'h200, 2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h32, 2'd0, 2'd0, 32'hBB223344));
        bq_req.push_back(mkreq(3'd0, 8'h33, 32'h300, 2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h33, 2'd0, 2'd0, 32'h0000CAFE));
        bq_req.push_back(mkreq(3'd0, 8'h34, 32'h100, 2'd2, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h34, 2'd0, 2'd2, 32'h00002233));
        burst(6, acc, low);
        check("bp_accepted", 64'(acc), 64'd3);
        check("bp_rdy_low_cycles", 64'(low), 64'd3);
        @(negedge clk);
        check("bp_req_rdy_low", 64'(req_rdy), 64'd0);
        held = resp_msg;
        check("bp_head", 64'(held), 64'(expq[0]));
        repeat (2) @(negedge clk);
        check("bp_hold", 64'(resp_msg), 64'(held));
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        wait_drain("bp");
        @(negedge clk);
        check("bp_req_rdy_back", 64'(req_rdy), 64'd1);
        @(posedge clk);
        #1;
        burst(4, acc, low);
        check("bp_rest_accepted", 64'(acc), 64'd2);
        wait_drain("bp_rest");

        // Reset with two requests in flight: nothing may emerge afterwards.
        resp_rdy = 1'b0;
        bq_req.push_back(mkreq(3'd0, 8'h38, 32'h100, 2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h38, 2'd0, 2'd0, 32'hDE112233));
        bq_req.push_back(mkreq(3'd0, 8'h39, 32'h200, 2'd0, 32'h0));
        bq_exp.push_back(mkresp(3'd0, 8'h39, 2'd0, 2'd0, 32'hBB223344));
        burst(4, acc, low);
        check("mid_rst_accepted", 64'(acc), 64'd2);
        @(negedge clk);
        reset = 1'b0;
        expq.delete();
        #1;
        check("mid_rst_req_rdy", 64'(req_rdy), 64'd0);
        check("mid_rst_resp_val", 64'(resp_val), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        resp_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_mid_rst_resp_val", 64'(resp_val), 64'd0);
        end
        @(posedge clk);
        #1;
        send_one(mkreq(3'd0, 8'h40, 32'h300, 2'd0, 32'h0),
                 mkresp(3'd0, 8'h40, 2'd0, 2'd0, 32'h0000CAFE), "after_rst");
        wait_drain("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
